// File: rtl/mem_line_xfer.sv
// mem_line_xfer: dCache miss engine, dirty-line write-back then line fill in bus beats.
// Optional idle-bus abort is compiled in with MEM_XFER_TIMEOUT_EN.
module mem_line_xfer #(
  parameter int LINE_BITS      = 512,
  parameter int BEAT_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cacheMiss,
  input  logic                 cacheEvictValid,
  input  logic [31:0]          aluResultMMU,
  input  logic [31:0]          evictAddr,
  input  logic [LINE_BITS-1:0] mmuDataOut,
  output logic [LINE_BITS-1:0] mmuDataIn,
  output logic                 mmuDataValid,
  output logic                 stallMem,
  output logic                 busReq,
  output logic                 busWe,
  output logic [31:0]          busAddr,
  output logic [BEAT_BITS-1:0] busWData,
  input  logic                 busReady,
  input  logic [BEAT_BITS-1:0] busRData,
  input  logic                 busRValid,
  output logic                 xferError
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int IW    = $clog2(BEATS);
  localparam int CW    = IW + 1;
  localparam int OFS   = $clog2(LINE_BITS / 8);
  localparam int BB    = $clog2(BEAT_BITS / 8);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [CW-1:0] FULL = CW'(BEATS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EVICT = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        evCnt;
  logic [CW-1:0]        reqCnt;
  logic [CW-1:0]        rspCnt;
  logic [31:0]          fillBase;
  logic [31:0]          evictBase;
  logic [LINE_BITS-1:0] evictLine;
  logic                 abort;
  logic                 rdIssue;
  logic                 rdAcc;
  logic                 rdRsp;
  logic                 unusedBits;

  assign unusedBits = ^{aluResultMMU[OFS-1:0], evictAddr[OFS-1:0], TIMEOUT_CYCLES};

  assign rdIssue = (state == FILL) && (reqCnt != FULL);
  assign rdAcc   = rdIssue && busReady;
  assign rdRsp   = (state == FILL) && busRValid && (rspCnt != FULL);

  assign stallMem     = (state != IDLE) | cacheMiss;
  assign mmuDataValid = (state == DONE);

  always_comb begin
    busReq   = 1'b0;
    busWe    = 1'b0;
    busAddr  = '0;
    busWData = '0;
    case (state)
      EVICT: begin
        busReq   = 1'b1;
        busWe    = 1'b1;
        busAddr  = evictBase + (32'(evCnt[IW-1:0]) << BB);
        busWData = evictLine[BEAT_BITS*int'(evCnt[IW-1:0]) +: BEAT_BITS];
      end
      FILL: begin
        busReq = rdIssue;
        if (rdIssue) busAddr = fillBase + (32'(reqCnt[IW-1:0]) << BB);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      evCnt     <= '0;
      reqCnt    <= '0;
      rspCnt    <= '0;
      fillBase  <= '0;
      evictBase <= '0;
      evictLine <= '0;
      mmuDataIn <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cacheMiss) begin
            fillBase  <= {aluResultMMU[31:OFS], {OFS{1'b0}}};
            evictBase <= {evictAddr[31:OFS], {OFS{1'b0}}};
            evictLine <= mmuDataOut;
            evCnt     <= '0;
            reqCnt    <= '0;
            rspCnt    <= '0;
            state     <= cacheEvictValid ? EVICT : FILL;
          end
        end
        EVICT: begin
          if (abort) begin
            state <= IDLE;
          end else if (busReady) begin
            evCnt <= evCnt + CW'(1);
            if (evCnt == LAST) state <= FILL;
          end
        end
        FILL: begin
          if (rdAcc) reqCnt <= reqCnt + CW'(1);
          if (rdRsp) begin
            rspCnt <= rspCnt + CW'(1);
            for (int b = 0; b < BEATS; b++) begin
              if (rspCnt[IW-1:0] == IW'(b))
                mmuDataIn[b*BEAT_BITS +: BEAT_BITS] <= busRData;
            end
          end
          if (abort) state <= IDLE;
          else if (rdRsp && rspCnt == LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_XFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] toCnt;
  logic          busy;
  logic          active;

  assign busy   = (state == EVICT) || (state == FILL);
  assign active = (busReq && busReady) || busRValid;
  // abort lands on the TIMEOUT_CYCLES-th consecutive idle cycle
  assign abort  = busy && !active && (toCnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toCnt     <= '0;
      xferError <= 1'b0;
    end else begin
      if (!busy || active || abort) toCnt <= '0;
      else toCnt <= toCnt + TW'(1);
      if (abort) xferError <= 1'b1;
    end
  end
`else
  assign abort     = 1'b0;
  assign xferError = 1'b0;
`endif

endmodule
